// File: rtl/eth_mac_rx_parser.sv
// eth_mac_rx_parser: strips preamble, filters dst MAC, withholds FCS, streams payload with CRC/length status; MAC_RX_STATS_EN adds frame counters
module eth_mac_rx_parser #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        mac_rxc,
  input  logic        rst,
  input  logic        mac_rxv,
  input  logic [7:0]  mac_rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_good,
  output logic [47:0] src_mac,
  output logic [15:0] eth_type
`ifdef MAC_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_crc_err,
  output logic [15:0] stat_drop
`endif
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;
  state_t state;
  logic [3:0] hdr_cnt;
  logic [55:0] hdr;
  logic [4:0][7:0] dl;
  logic [2:0] fill;
  logic first;
  logic [31:0] crc, crc_next;
  logic [15:0] len, len_next;
  logic pend_v, pend_sop, pend_eop, pend_good;
  logic [7:0] pend_data;
  logic frame_ok, end_pay, emit_last, dst_bad, pre_bad;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
    return r;
  endfunction
  always_comb begin
    crc_next = crc_byte(crc, mac_rxd);
    len_next = (len == 16'hFFFF) ? len : len + 16'd1;
    frame_ok = (crc == 32'hDEBB20E3) && (len >= 16'(MIN_FRAME_LEN)) && (len <= 16'(MAX_FRAME_LEN));
    end_pay = (state == PAYLOAD) && !mac_rxv;
    emit_last = end_pay && (fill == 3'd5);
    dst_bad = (hdr_cnt == 4'd5) && ({hdr[39:0], mac_rxd} != LOCAL_MAC) && ({hdr[39:0], mac_rxd} != 48'hFFFF_FFFF_FFFF);
    pre_bad = (mac_rxd != 8'h55) && (mac_rxd != 8'hD5);
  end
  always_ff @(posedge mac_rxc) begin
    if (rst) begin
      state <= IDLE;
      hdr_cnt <= '0;
      hdr <= '0;
      dl <= '0;
      fill <= '0;
      first <= 1'b0;
      crc <= '1;
      len <= '0;
      {pend_v, pend_sop, pend_eop, pend_good, pend_data} <= '0;
      {out_valid, out_sop, out_eop, out_good, out_data} <= '0;
      src_mac <= '0;
      eth_type <= '0;
    end else begin
      {pend_v, pend_sop, pend_eop, pend_good} <= '0;
      out_valid <= pend_v;
      out_data <= pend_data;
      out_sop <= pend_sop;
      out_eop <= pend_eop;
      out_good <= pend_good;
      if (!mac_rxv) begin
        state <= IDLE;
        crc <= '1;
        len <= '0;
        fill <= '0;
        hdr_cnt <= '0;
        if (emit_last) begin
          pend_v <= 1'b1;
          pend_data <= dl[4];
          pend_sop <= first;
          pend_eop <= 1'b1;
          pend_good <= frame_ok;
        end
      end else begin
        case (state)
          IDLE, PREAMBLE: begin
            crc <= '1;
            len <= '0;
            hdr_cnt <= '0;
            state <= (mac_rxd == 8'h55) ? PREAMBLE : (mac_rxd == 8'hD5) ? HEADER : DROP;
          end
          HEADER: begin
            crc <= crc_next;
            len <= len_next;
            hdr <= {hdr[47:0], mac_rxd};
            hdr_cnt <= hdr_cnt + 4'd1;
            if (dst_bad) state <= DROP;
            if (hdr_cnt == 4'd13) begin
              src_mac <= hdr[55:8];
              eth_type <= {hdr[7:0], mac_rxd};
              state <= PAYLOAD;
              first <= 1'b1;
              fill <= '0;
            end
          end
          PAYLOAD: begin
            crc <= crc_next;
            len <= len_next;
            dl <= {dl[3:0], mac_rxd};
            if (fill == 3'd5) begin
              pend_v <= 1'b1;
              pend_data <= dl[4];
              pend_sop <= first;
              first <= 1'b0;
            end else fill <= fill + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef MAC_RX_STATS_EN
  logic ev_good, ev_crc, ev_drop;
  always_comb begin
    ev_good = emit_last && frame_ok;
    ev_crc = emit_last && (crc != 32'hDEBB20E3);
    ev_drop = (mac_rxv && (state == IDLE || state == PREAMBLE) && pre_bad) ||
              (mac_rxv && state == HEADER && dst_bad) ||
              (!mac_rxv && state == HEADER) || (end_pay && fill != 3'd5);
  end
  always_ff @(posedge mac_rxc) begin
    if (rst) begin
      stat_good <= '0;
      stat_crc_err <= '0;
      stat_drop <= '0;
    end else begin
      stat_good <= stat_good + {15'd0, ev_good && stat_good != 16'hFFFF};
      stat_crc_err <= stat_crc_err + {15'd0, ev_crc && stat_crc_err != 16'hFFFF};
      stat_drop <= stat_drop + {15'd0, ev_drop && stat_drop != 16'hFFFF};
    end
  end
`else
  logic unused_pre_bad;
  assign unused_pre_bad = pre_bad;
`endif
endmodule

// File: tb/tb_eth_mac_rx_parser.sv
// tb_eth_mac_rx_parser: directed frames with a scoreboard queue checked by an output monitor
module tb_eth_mac_rx_parser;
  localparam logic [47:0] LOCAL = 48'h00_0A_35_01_02_03;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h11_22_33_44_55_66;
  logic clk = 1'b0, rst = 1'b1, rxv = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic out_valid, out_sop, out_eop, out_good;
  logic [7:0] out_data;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
`ifdef MAC_RX_STATS_EN
  logic [15:0] stat_good, stat_crc_err, stat_drop;
`endif
  eth_mac_rx_parser dut (
    .mac_rxc(clk), .rst(rst), .mac_rxv(rxv), .mac_rxd(rxd),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_good(out_good), .src_mac(src_mac), .eth_type(eth_type)
`ifdef MAC_RX_STATS_EN
    , .stat_good(stat_good), .stat_crc_err(stat_crc_err), .stat_drop(stat_drop)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [7:0] d;
    logic sop, eop, good;
    logic [47:0] src;
    logic [15:0] typ;
    int at;
  } exp_t;
  exp_t q[$];
  int checks = 0, passes = 0;
  int e_good = 0, e_crc = 0, e_drop = 0;
  logic [7:0] fr [0:1599];
  int flen;
  logic exp_good;
  logic [47:0] f_src;
  logic [15:0] f_typ;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) $display("FAIL %s act=%h exp=%h", n, a, e);
    else passes++;
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_byte", {out_data, out_sop, out_eop}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("payload", {out_data, out_sop, out_eop, out_good & out_eop, src_mac, eth_type, 32'(cyc)},
            {e.d, e.sop, e.eop, e.good & e.eop, e.src, e.typ, 32'(e.at)});
      end
    end
  end
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction
  task automatic make_frame(input logic [47:0] dst, input logic [15:0] typ, input int plen,
                            input logic [7:0] seed, input bit corrupt);
    logic [31:0] c;
    logic [111:0] h;
    h = {dst, SRC, typ};
    for (int i = 0; i < 14; i++) fr[i] = h[111-8*i -: 8];
    for (int i = 0; i < plen; i++) fr[14+i] = 8'(seed + i);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 14 + plen; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr[14+plen+i] = c[8*i +: 8];
    flen = 18 + plen;
    if (corrupt) fr[flen-1] = fr[flen-1] ^ 8'h01;
    exp_good = !corrupt && flen >= 64 && flen <= 1518;
    f_src = SRC;
    f_typ = typ;
  endtask
  task automatic drive(input logic v, input logic [7:0] b);
    rxv = v;
    rxd = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input bit deliver, input int gap, input int abort_at);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < flen; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        drive(1'b1, fr[i]);
        rst = 1'b0;
        rxv = 1'b0;
        chk("reset_mid_frame", {out_valid, out_sop, out_eop, out_good, out_data, src_mac, eth_type}, 0);
        for (int g = 0; g < gap; g++) drive(1'b0, 8'h00);
        return;
      end
      drive(1'b1, fr[i]);
      if (deliver && i >= 14 && i < flen - 4)
        q.push_back('{d: fr[i], sop: i == 14, eop: i == flen - 5, good: exp_good,
                      src: f_src, typ: f_typ, at: cyc + 6});
    end
    if (deliver) begin
      if (exp_good) e_good++;
      if (fr[flen-1] !== 8'h00 && !exp_good && flen >= 64 && flen <= 1518) e_crc++;
    end
    for (int g = 0; g < gap; g++) drive(1'b0, 8'h00);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_sop, out_eop, out_good, out_data, src_mac, eth_type}, 0);
    rst = 1'b0;
    drive(1'b0, 8'h00);
    make_frame(LOCAL, 16'h0806, 46, 8'h00, 1'b0);
    chk("f1_expect_good", exp_good, 1'b1);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0806, 46, 8'h00, 1'b1);
    send_frame(1'b1, 4, -1);
    make_frame(48'h02_00_00_00_00_99, 16'h0800, 46, 8'h40, 1'b0);
    send_frame(1'b0, 4, -1);
    e_drop++;
    make_frame(BCAST, 16'h0806, 28, 8'h10, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(BCAST, 16'h0800, 1, 8'hA5, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0800, 45, 8'h20, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0800, 1500, 8'h33, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0800, 1501, 8'h44, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0800, 46, 8'h80, 1'b0);
    send_frame(1'b1, 1, -1);
    make_frame(BCAST, 16'h86DD, 46, 8'hC0, 1'b0);
    send_frame(1'b1, 4, -1);
    make_frame(LOCAL, 16'h0800, 46, 8'h55, 1'b0);
    send_frame(1'b0, 4, 16);
    make_frame(LOCAL, 16'h0806, 46, 8'h60, 1'b0);
    send_frame(1'b1, 4, -1);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
`ifdef MAC_RX_STATS_EN
    chk("stat_good", stat_good, e_good);
    chk("stat_crc_err", stat_crc_err, 1);
    chk("stat_drop", stat_drop, e_drop);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
